// File: rtl/axis_frame_receiver.sv
// Pixel AXI-stream sink: checks SOF/EOL framing and writes pixels linearly into a frame buffer.
// Optional define FRAME_CHECKSUM_EN adds per-frame wrapping channel sums (sum_r/sum_g/sum_b).
module axis_frame_receiver #(
    parameter int Nrows = 480,
    parameter int Ncol  = 640,
    parameter int AW    = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tuser,
    input  logic          s_axis_tlast,
    input  logic [23:0]   s_axis_tdata,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [23:0]   wr_data,
    output logic          frame_done,
    output logic          busy,
    output logic          err_sof,
    output logic          err_eol,
    output logic [15:0]   frame_cnt
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [31:0]   sum_r,
    output logic [31:0]   sum_g,
    output logic [31:0]   sum_b
`endif
);

    localparam int CW = (Ncol  > 1) ? $clog2(Ncol)  : 1;
    localparam int RW = (Nrows > 1) ? $clog2(Nrows) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(Ncol - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(Nrows - 1);
    localparam logic [AW-1:0] NCOL_A   = AW'(Ncol);

    typedef enum logic {IDLE, RECV} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [23:0]   wr_data_q, wr_data_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q, busy_d;
    logic          err_sof_q, err_sof_d;
    logic          err_eol_q, err_eol_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          col_at_end;
    logic          row_end;

`ifdef FRAME_CHECKSUM_EN
    logic [31:0] acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
    logic [31:0] sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
    logic [31:0] pix_r, pix_g, pix_b;

    assign pix_r = {24'b0, s_axis_tdata[23:16]};
    assign pix_g = {24'b0, s_axis_tdata[15:8]};
    assign pix_b = {24'b0, s_axis_tdata[7:0]};
`endif

    assign col_at_end = (col_q == COL_LAST);
    assign row_end    = col_at_end || s_axis_tlast;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        row_base_d   = row_base_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        err_sof_d    = 1'b0;
        err_eol_d    = 1'b0;
        frame_cnt_d  = frame_cnt_q;
`ifdef FRAME_CHECKSUM_EN
        acc_r_d = acc_r_q;
        acc_g_d = acc_g_q;
        acc_b_d = acc_b_q;
        sum_r_d = sum_r_q;
        sum_g_d = sum_g_q;
        sum_b_d = sum_b_q;
`endif

        if (s_axis_tvalid) begin
            if (s_axis_tuser) begin
                // SOF always restarts the frame, from IDLE or as a mid-frame resync; tlast is ignored.
                err_sof_d  = (state_q == RECV);
                wr_en_d    = 1'b1;
                wr_addr_d  = '0;
                wr_data_d  = s_axis_tdata;
                col_d      = CW'(1);
                row_d      = '0;
                addr_d     = AW'(1);
                row_base_d = '0;
                state_d    = RECV;
`ifdef FRAME_CHECKSUM_EN
                acc_r_d = pix_r;
                acc_g_d = pix_g;
                acc_b_d = pix_b;
`endif
            end else if (state_q == RECV) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = s_axis_tdata;
                err_eol_d = (col_at_end != s_axis_tlast);
`ifdef FRAME_CHECKSUM_EN
                acc_r_d = acc_r_q + pix_r;
                acc_g_d = acc_g_q + pix_g;
                acc_b_d = acc_b_q + pix_b;
`endif
                if (row_end) begin
                    col_d      = '0;
                    row_d      = row_q + RW'(1);
                    row_base_d = row_base_q + NCOL_A;
                    addr_d     = row_base_q + NCOL_A;
                    if (row_q == ROW_LAST) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        row_d        = '0;
                        row_base_d   = '0;
                        addr_d       = '0;
`ifdef FRAME_CHECKSUM_EN
                        sum_r_d = acc_r_q + pix_r;
                        sum_g_d = acc_g_q + pix_g;
                        sum_b_d = acc_b_q + pix_b;
`endif
                    end
                end else begin
                    col_d  = col_q + CW'(1);
                    addr_d = addr_q + AW'(1);
                end
            end
        end

        busy_d = (state_d == RECV) || frame_done_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            row_base_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_sof_q    <= 1'b0;
            err_eol_q    <= 1'b0;
            frame_cnt_q  <= '0;
`ifdef FRAME_CHECKSUM_EN
            acc_r_q <= '0;
            acc_g_q <= '0;
            acc_b_q <= '0;
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            row_base_q   <= row_base_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            err_sof_q    <= err_sof_d;
            err_eol_q    <= err_eol_d;
            frame_cnt_q  <= frame_cnt_d;
`ifdef FRAME_CHECKSUM_EN
            acc_r_q <= acc_r_d;
            acc_g_q <= acc_g_d;
            acc_b_q <= acc_b_d;
            sum_r_q <= sum_r_d;
            sum_g_q <= sum_g_d;
            sum_b_q <= sum_b_d;
`endif
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign err_sof    = err_sof_q;
    assign err_eol    = err_eol_q;
    assign frame_cnt  = frame_cnt_q;
`ifdef FRAME_CHECKSUM_EN
    assign sum_r = sum_r_q;
    assign sum_g = sum_g_q;
    assign sum_b = sum_b_q;
`endif

endmodule

// File: doc/axis_frame_receiver.md
Name: axis_frame_receiver

Overview:
Sink end of the pixel AXI-stream used by gamma_correction and frame_generator. It consumes the 24-bit RGB stream (tvalid/tuser/tlast, no tready) and writes each pixel into a frame buffer through a simple write port. It checks SOF/EOL framing against Nrows x Ncol and pulses frame_done when a full frame has been captured. It sits downstream of gamma_correction's m_axis port and feeds the capture RAM.

Parameters:
Nrows, 480, rows per frame (>=2)
Ncol, 640, pixels per row (>=2)
AW, 19, write address width; must satisfy 2^AW >= Nrows*Ncol

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
s_axis_tvalid  in  1  pixel beat valid
s_axis_tuser  in  1  start of frame, first pixel
s_axis_tlast  in  1  end of line, last pixel of row
s_axis_tdata  in  24  pixel, R[23:16] G[15:8] B[7:0]
wr_en  out  1  frame-buffer write strobe
wr_addr  out  AW  linear pixel address, row*Ncol+col
wr_data  out  24  pixel to write
frame_done  out  1  one-cycle pulse, full frame written
busy  out  1  high while a frame is in progress
err_sof  out  1  one-cycle pulse, tuser seen mid-frame
err_eol  out  1  one-cycle pulse, tlast position mismatch
frame_cnt  out  16  completed frames, wraps at 65535->0

Behaviour:
- Single clock domain. All logic is synchronous to the rising edge of clk.
- Reset: rst=0 sampled at a clk edge forces state IDLE, col/row/addr=0, and all outputs to 0. A partial frame is discarded and no frame_done is issued.
- A beat is a cycle with s_axis_tvalid=1. Cycles without tvalid leave all counters unchanged and wr_en=0. Gaps are allowed anywhere.
- Address generation uses an incrementing counter plus a row_base register; no multiplier.
- States:
  - IDLE:
    - beat with tuser=0: discarded, no error raised.
    - beat with tuser=1: pixel written at addr 0, col=1, row=0, go to RECV.
  - RECV, on each beat with tuser=0:
    - write pixel at current addr.
    - col==Ncol-1 and tlast=1: normal end of line; col=0, row+1, row_base+=Ncol.
    - col==Ncol-1 and tlast=0: err_eol pulse; wrap as in the normal case.
    - col<Ncol-1 and tlast=1: err_eol pulse; early end of line, pixel written; col=0, row+1, addr jumps to the new row_base.
    - last beat of row Nrows-1 (col==Ncol-1, or early tlast): frame complete; go to IDLE; frame_done pulses and frame_cnt increments.
  - RECV, beat with tuser=1: err_sof pulse; resynchronise by treating the beat as the first pixel of a new frame (addr 0, col=1, row=0). No frame_done is issued for the aborted frame.
- Timing: outputs are registered, so wr_en/wr_addr/wr_data appear one cycle after the accepted beat. frame_done and err_* pulses are aligned with the wr_en of the beat that caused them.
- Back-to-back frames: the cycle after the final beat may carry tuser for the next frame, which is accepted with zero gap.
- busy=1 from the cycle after the SOF beat through the cycle the last pixel is written (the same cycle as frame_done).
- A single beat with both tuser=1 and tlast=1 is SOF handling only; tlast is ignored.

Optional Feature:
Macro FRAME_CHECKSUM_EN.
- Defined:
  - Extra outputs sum_r, sum_g, sum_b, each 32 bits (unsigned, wrapping).
  - Internal accumulators clear on every accepted SOF beat and add each written pixel's channel.
  - The outputs latch the final sums in the same cycle frame_done pulses and hold until the next frame_done or reset.
  - Reset value is 0.
- Undefined: these ports and the accumulators do not exist; all other behaviour is identical.

Test Plan:
- Nrows=4, Ncol=4, frame pixels 0x000000..0x00000F with correct tuser/tlast -> 16 writes at addr 0..15 with matching data; frame_done once, aligned with addr 15; frame_cnt=1; no err pulses.
- Same frame with tvalid low every other cycle -> identical write sequence, no errors.
- Two frames back to back, no gap -> 32 writes; addr restarts at 0; frame_done twice; frame_cnt=2.
- tlast asserted at col 2 of row 1 -> err_eol pulse; next pixel written at addr 8; frame_done after row 3 completes.
- tuser asserted at pixel 6 -> err_sof pulse; that pixel written at addr 0; frame_done only after 16 pixels counted from the restart.
- rst=0 after 5 pixels, then a full frame -> outputs 0 during reset; no frame_done for the partial frame; the clean frame completes normally. With FRAME_CHECKSUM_EN: all pixels 0x010203 -> sum_r=16, sum_g=32, sum_b=48.
